// File: rtl/i2c_target_regfile.sv
// I2C target with 7-bit address match, register pointer and auto-incrementing
// register file, plus a local host port into the same registers.
module i2c_target_regfile #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         NUM_REGS    = 4,
  parameter int         PTR_W       = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  input  logic [PTR_W-1:0] host_addr,
  input  logic             host_wr_en,
  input  logic [7:0]       host_wr_data,
  output logic [7:0]       host_rd_data,
  output logic             wr_event,
  output logic             busy,
  output logic [PTR_W-1:0] ptr
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_PTR       = 4'd3,
    S_PTR_ACK   = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RDATA     = 4'd7,
    S_RDATA_ACK = 4'd8,
    S_IGNORE    = 4'd9
  } state_t;

  logic             scl_meta_r, scl_sync_r, scl_hist_r;
  logic             sda_meta_r, sda_sync_r, sda_hist_r;
  logic             scl_rise_s, scl_fall_s, start_s, stop_s;
  state_t           state_r, state_s;
  logic [2:0]       cnt_r, cnt_s;
  logic [7:0]       shift_r, shift_s, rx_byte_s;
  logic [PTR_W-1:0] ptr_r, ptr_s, ptr_inc_s;
  logic             sda_oe_r, oe_s, busy_r, busy_s, rw_r, rw_s;
  logic             ack_ph_r, ack_ph_s, rd_first_r, rd_first_s;
  logic             wr_fire_s, wr_event_r;
  logic [7:0]       regs_r [NUM_REGS];

  // Line synchronizers plus one history flop; preset to the idle-high bus level
  always_ff @(posedge clk) begin
    if (reset) begin
      {scl_meta_r, scl_sync_r, scl_hist_r} <= 3'b111;
      {sda_meta_r, sda_sync_r, sda_hist_r} <= 3'b111;
    end else begin
      {scl_meta_r, scl_sync_r, scl_hist_r} <= {scl_in, scl_meta_r, scl_sync_r};
      {sda_meta_r, sda_sync_r, sda_hist_r} <= {sda_in, sda_meta_r, sda_sync_r};
    end
  end

  assign scl_rise_s = scl_sync_r & ~scl_hist_r;
  assign scl_fall_s = ~scl_sync_r & scl_hist_r;
  assign start_s    = scl_sync_r & scl_hist_r & sda_hist_r & ~sda_sync_r;
  assign stop_s     = scl_sync_r & scl_hist_r & ~sda_hist_r & sda_sync_r;
  assign rx_byte_s  = {shift_r[6:0], sda_sync_r};
  assign ptr_inc_s  = ptr_r + PTR_W'(1);

  // Next-state and datapath decode for the bus protocol engine
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    shift_s    = shift_r;
    ptr_s      = ptr_r;
    oe_s       = sda_oe_r;
    busy_s     = busy_r;
    rw_s       = rw_r;
    ack_ph_s   = ack_ph_r;
    rd_first_s = rd_first_r;
    wr_fire_s  = 1'b0;
    if (stop_s) begin
      state_s = S_IDLE;
      oe_s    = 1'b0;
      busy_s  = 1'b0;
    end else if (start_s) begin
      state_s  = S_ADDR;
      cnt_s    = 3'd0;
      oe_s     = 1'b0;
      ack_ph_s = 1'b0;
    end else begin
      case (state_r)
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise_s) begin
            shift_s  = rx_byte_s;
            cnt_s    = cnt_r + 3'd1;
            ack_ph_s = 1'b0;
            if (cnt_r == 3'd7) begin
              if (state_r == S_ADDR) begin
                if (rx_byte_s[7:1] == TARGET_ADDR) begin
                  state_s = S_ADDR_ACK;
                  rw_s    = rx_byte_s[0];
                  busy_s  = 1'b1;
                end else begin
                  state_s = S_IGNORE;
                  busy_s  = 1'b0;
                end
              end else if (state_r == S_PTR) begin
                ptr_s   = rx_byte_s[PTR_W-1:0];
                state_s = S_PTR_ACK;
              end else begin
                wr_fire_s = 1'b1;
                ptr_s     = ptr_inc_s;
                state_s   = S_WDATA_ACK;
              end
            end else begin
              state_s = state_r;
            end
          end else begin
            state_s = state_r;
          end
        end
        // Drive ACK on the first fall, release on the second and move on
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall_s) begin
            if (!ack_ph_r) begin
              oe_s     = 1'b1;
              ack_ph_s = 1'b1;
            end else begin
              oe_s     = 1'b0;
              ack_ph_s = 1'b0;
              cnt_s    = 3'd0;
              if (state_r == S_ADDR_ACK && rw_r) begin
                state_s    = S_RDATA;
                shift_s    = regs_r[ptr_r];
                oe_s       = ~regs_r[ptr_r][7];
                rd_first_s = 1'b0;
              end else if (state_r == S_ADDR_ACK) begin
                state_s = S_PTR;
              end else begin
                state_s = S_WDATA;
              end
            end
          end else begin
            state_s = state_r;
          end
        end
        S_RDATA: begin
          if (scl_fall_s) begin
            if (rd_first_r) begin
              oe_s       = ~shift_r[7];
              rd_first_s = 1'b0;
              cnt_s      = 3'd0;
            end else if (cnt_r == 3'd7) begin
              oe_s    = 1'b0;
              state_s = S_RDATA_ACK;
            end else begin
              shift_s = {shift_r[6:0], 1'b0};
              oe_s    = ~shift_r[6];
              cnt_s   = cnt_r + 3'd1;
            end
          end else begin
            state_s = state_r;
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise_s) begin
            ptr_s = ptr_inc_s;
            if (!sda_sync_r) begin
              state_s    = S_RDATA;
              shift_s    = regs_r[ptr_inc_s];
              rd_first_s = 1'b1;
            end else begin
              state_s = S_IGNORE;
              busy_s  = 1'b0;
            end
          end else begin
            state_s = state_r;
          end
        end
        S_IDLE, S_IGNORE: begin
          oe_s = 1'b0;
        end
        default: begin
          state_s = S_IDLE;
          oe_s    = 1'b0;
          busy_s  = 1'b0;
        end
      endcase
    end
  end

  // Protocol state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      cnt_r      <= 3'd0;
      shift_r    <= 8'h00;
      ptr_r      <= '0;
      sda_oe_r   <= 1'b0;
      busy_r     <= 1'b0;
      rw_r       <= 1'b0;
      ack_ph_r   <= 1'b0;
      rd_first_r <= 1'b0;
      wr_event_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      shift_r    <= shift_s;
      ptr_r      <= ptr_s;
      sda_oe_r   <= oe_s;
      busy_r     <= busy_s;
      rw_r       <= rw_s;
      ack_ph_r   <= ack_ph_s;
      rd_first_r <= rd_first_s;
      wr_event_r <= wr_fire_s;
    end
  end

  // Register file; a bus commit overrides a host write to the same index
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reset) begin
        regs_r[i] <= 8'h00;
      end else if (wr_fire_s && (ptr_r == PTR_W'(i))) begin
        regs_r[i] <= rx_byte_s;
      end else if (host_wr_en && (host_addr == PTR_W'(i))) begin
        regs_r[i] <= host_wr_data;
      end
    end
  end

  assign host_rd_data = regs_r[host_addr];
  assign sda_oe       = sda_oe_r;
  assign wr_event     = wr_event_r;
  assign busy         = busy_r;
  assign ptr          = ptr_r;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: a bit-banged I2C master drives the
// open-drain bus and every result is compared against hand-computed values.
module tb_i2c_target_regfile;

  localparam int Q = 5;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m, sda_m;
  logic       sda_line;
  logic       sda_oe, wr_event, busy;
  logic [1:0] host_addr, ptr;
  logic       host_wr_en;
  logic [7:0] host_wr_data, host_rd_data;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int oe_cnt   = 0;

  assign sda_line = sda_m & ~sda_oe;

  i2c_target_regfile #(.TARGET_ADDR(7'h50), .NUM_REGS(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_line), .sda_oe(sda_oe),
    .host_addr(host_addr), .host_wr_en(host_wr_en), .host_wr_data(host_wr_data),
    .host_rd_data(host_rd_data), .wr_event(wr_event), .busy(busy), .ptr(ptr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_event) wr_cnt++;
    if (sda_oe) oe_cnt++;
  end

  typedef struct {
    logic [7:0] ptr_b;
    logic [7:0] data;
    logic [1:0] idx;
    logic [1:0] exp_ptr;
  } wvec_t;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] data;
  } hvec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    wq(); sda_m = b;
    wq(); scl_m = 1'b1;
    wq(); s = sda_line;
    wq(); scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    wq(); sda_m = 1'b0;
    wq(); scl_m = 1'b0;
  endtask

  task automatic i2c_rstart();
    wq(); sda_m = 1'b1;
    wq(); scl_m = 1'b1;
    wq(); sda_m = 1'b0;
    wq(); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wq(); sda_m = 1'b0;
    wq(); scl_m = 1'b1;
    wq(); sda_m = 1'b1;
    wq();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic d;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], d);
    bit_xfer(1'b1, d);
    ack = ~d;
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] b);
    logic d;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, d);
      b[i] = d;
    end
    bit_xfer(ack_bit, d);
  endtask

  task automatic chk_reg(input string name, input logic [1:0] idx, input logic [7:0] exp);
    host_addr = idx;
    #1;
    chk(name, 32'(host_rd_data), 32'(exp));
  endtask

  initial begin
    wvec_t      wv [4];
    hvec_t      hv [4];
    logic       a0, a1, a2, a3;
    logic [7:0] rb;
    int         wr0, oe0;

    wv[0] = '{8'hFE, 8'hC3, 2'd2, 2'd3};
    wv[1] = '{8'h03, 8'h81, 2'd3, 2'd0};
    wv[2] = '{8'h40, 8'h0F, 2'd0, 2'd1};
    wv[3] = '{8'h05, 8'hE7, 2'd1, 2'd2};
    hv[0] = '{2'd0, 8'h11};
    hv[1] = '{2'd1, 8'h22};
    hv[2] = '{2'd2, 8'h33};
    hv[3] = '{2'd3, 8'h44};

    reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    host_addr = 2'd0; host_wr_en = 1'b0; host_wr_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ptr", 32'(ptr), 32'd0);
    chk("rst_wr_event", 32'(wr_event), 32'd0);
    for (int i = 0; i < 4; i++) chk_reg("rst_reg", 2'(i), 8'h00);

    // Table: single-byte writes exercising pointer truncation and wrap
    for (int i = 0; i < 4; i++) begin
      wr0 = wr_cnt;
      i2c_start();
      write_byte(8'hA0, a0);
      write_byte(wv[i].ptr_b, a1);
      write_byte(wv[i].data, a2);
      i2c_stop();
      chk("vec_acks", 32'(a0 & a1 & a2), 32'd1);
      chk_reg("vec_reg", wv[i].idx, wv[i].data);
      chk("vec_ptr", 32'(ptr), 32'(wv[i].exp_ptr));
      chk("vec_wr_event", 32'(wr_cnt - wr0), 32'd1);
    end

    // Two-byte write with ACK on every byte
    wr0 = wr_cnt;
    i2c_start();
    write_byte(8'hA0, a0);
    chk("wr_busy", 32'(busy), 32'd1);
    write_byte(8'h01, a1);
    write_byte(8'h3C, a2);
    write_byte(8'h5A, a3);
    i2c_stop();
    chk("wr_acks", 32'({a0, a1, a2, a3}), 32'hF);
    chk_reg("wr_reg1", 2'd1, 8'h3C);
    chk_reg("wr_reg2", 2'd2, 8'h5A);
    chk("wr_events", 32'(wr_cnt - wr0), 32'd2);
    chk("wr_ptr", 32'(ptr), 32'd3);
    chk("wr_busy_after", 32'(busy), 32'd0);

    // Host preload through the local port
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      host_addr = hv[i].addr; host_wr_data = hv[i].data; host_wr_en = 1'b1;
      @(negedge clk);
      host_wr_en = 1'b0;
      chk("host_wr_rd", 32'(host_rd_data), 32'(hv[i].data));
    end

    // Combined write-pointer / repeated START / read
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h02, a1);
    i2c_rstart();
    write_byte(8'hA1, a2);
    chk("rd_acks", 32'({a0, a1, a2}), 32'h7);
    read_byte(1'b0, rb);
    chk("rd_byte0", 32'(rb), 32'h33);
    read_byte(1'b1, rb);
    chk("rd_byte1", 32'(rb), 32'h44);
    i2c_stop();
    chk("rd_ptr_wrap", 32'(ptr), 32'd0);

    // Address mismatch: never touches the bus or registers
    wr0 = wr_cnt; oe0 = oe_cnt;
    i2c_start();
    write_byte(8'hA2, a0);
    chk("mm_busy", 32'(busy), 32'd0);
    write_byte(8'h01, a1);
    write_byte(8'h99, a2);
    i2c_stop();
    chk("mm_oe_cycles", 32'(oe_cnt - oe0), 32'd0);
    chk("mm_wr_events", 32'(wr_cnt - wr0), 32'd0);
    chk_reg("mm_reg1", 2'd1, 8'h22);
    chk("mm_ptr", 32'(ptr), 32'd0);

    // Pointer truncation and wrap across two data bytes
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h07, a1);
    write_byte(8'hAA, a2);
    write_byte(8'hBB, a3);
    i2c_stop();
    chk_reg("wrap_reg3", 2'd3, 8'hAA);
    chk_reg("wrap_reg0", 2'd0, 8'hBB);
    chk("wrap_ptr", 32'(ptr), 32'd1);

    // STOP in the middle of a data byte discards it
    wr0 = wr_cnt;
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h01, a1);
    for (int i = 0; i < 4; i++) bit_xfer(1'b1, a2);
    i2c_stop();
    chk("abort_wr_events", 32'(wr_cnt - wr0), 32'd0);
    chk_reg("abort_reg1", 2'd1, 8'h22);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_oe", 32'(sda_oe), 32'd0);
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h02, a1);
    write_byte(8'h55, a2);
    i2c_stop();
    chk("post_abort_acks", 32'({a0, a1, a2}), 32'h7);
    chk_reg("post_abort_reg2", 2'd2, 8'h55);
    chk("post_abort_ptr", 32'(ptr), 32'd3);

    // Host write colliding with the bus commit to the same register
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h01, a1);
    fork
      write_byte(8'h77, a2);
      begin
        int n;
        n = 0;
        host_addr = 2'd1; host_wr_data = 8'hEE; host_wr_en = 1'b1;
        while (!wr_event && n < 2000) begin
          @(negedge clk);
          n++;
        end
        host_wr_en = 1'b0;
        chk("coll_event_seen", 32'(wr_event), 32'd1);
      end
    join
    i2c_stop();
    chk_reg("coll_reg1", 2'd1, 8'h77);
    chk("coll_ptr", 32'(ptr), 32'd2);

    // Reset while the target is pulling SDA low for a read bit
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h01, a1);
    i2c_rstart();
    write_byte(8'hA1, a2);
    chk("rstrd_oe_low", 32'(sda_oe), 32'd1);
    chk("rstrd_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rstrd_oe", 32'(sda_oe), 32'd0);
    chk("rstrd_busy_clr", 32'(busy), 32'd0);
    chk("rstrd_ptr", 32'(ptr), 32'd0);
    for (int i = 0; i < 4; i++) chk_reg("rstrd_reg", 2'(i), 8'h00);
    scl_m = 1'b1; sda_m = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
